// File: rtl/tl_pkg.sv
// Shared types and constants for the traffic light controller checkers:
// light phase and monitor state encodings, seven-segment digit patterns
// (segments a..g on bits 0..6), error flag bit positions and phase helpers.
package tl_pkg;

  typedef enum logic [1:0] {
    GREEN   = 2'd0,
    YELLOW  = 2'd1,
    RED     = 2'd2,
    INVALID = 2'd3
  } phase_t;

  typedef enum logic {
    ACQ   = 1'b0,
    TRACK = 1'b1
  } mon_state_t;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  localparam int ERR_W     = 5;
  localparam int ERR_LIGHT = 0;
  localparam int ERR_PED   = 1;
  localparam int ERR_SEG   = 2;
  localparam int ERR_SEQ   = 3;
  localparam int ERR_CNT   = 4;

  // car_light is {green,yellow,red}; anything not one-hot is INVALID
  function automatic phase_t light_to_phase(input logic [2:0] car);
    case (car)
      3'b100:  return GREEN;
      3'b010:  return YELLOW;
      3'b001:  return RED;
      default: return INVALID;
    endcase
  endfunction

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      GREEN:   return YELLOW;
      YELLOW:  return RED;
      RED:     return GREEN;
      default: return INVALID;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational seven-segment pattern to digit decoder. Only the ten
// canonical 0-9 patterns are legal; anything else reports o_valid=0.
module seg7_decoder (
  input  logic [6:0] i_seg,
  output logic [3:0] o_digit,
  output logic       o_valid
);
  import tl_pkg::*;

  // Pattern lookup; unknown codes return digit 0 with o_valid low
  always_comb begin
    o_digit = 4'd0;
    o_valid = 1'b1;
    case (i_seg)
      SEG_0:   o_digit = 4'd0;
      SEG_1:   o_digit = 4'd1;
      SEG_2:   o_digit = 4'd2;
      SEG_3:   o_digit = 4'd3;
      SEG_4:   o_digit = 4'd4;
      SEG_5:   o_digit = 4'd5;
      SEG_6:   o_digit = 4'd6;
      SEG_7:   o_digit = 4'd7;
      SEG_8:   o_digit = 4'd8;
      SEG_9:   o_digit = 4'd9;
      default: o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for the traffic light controller outputs. On each tick it
// decodes the display, tracks the light phase, verifies the G->Y->R order and
// countdown against the programmed times, and keeps sticky error flags.
// Optional tick watchdog: define MON_TIMEOUT_EN to build the stall counter.
module traffic_light_monitor #(
  parameter int GREEN_TIME     = 9,
  parameter int YELLOW_TIME    = 3,
  parameter int RED_TIME       = 6,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [2:0]       car_light,
  input  logic             pedestrian_light,
  input  logic [7:0]       seg_display,
  input  logic             clear_err,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic [1:0]       phase,
  output logic             locked,
  output logic [4:0]       err_flags,
  output logic             err_pulse,
  output logic [CNT_W-1:0] cycle_count,
  output logic             stall
);
  import tl_pkg::*;

  mon_state_t       r_state, w_state_nxt;
  phase_t           r_phase, w_phase, w_exp_phase;
  logic [3:0]       r_digit, r_exp, w_dec_digit, w_exp_digit;
  logic             r_digit_valid, r_pulse;
  logic [ERR_W-1:0] r_err, w_new_err;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic             w_seg_ok, w_light_ok, w_ped_ok, w_acquire;
  logic             w_cycle_inc, w_timeout, w_locked, w_load_exp;
  logic             w_unused;

  // First displayed digit of each phase
  function automatic logic [3:0] phase_time(input phase_t p);
    case (p)
      GREEN:   return 4'(GREEN_TIME);
      YELLOW:  return 4'(YELLOW_TIME);
      RED:     return 4'(RED_TIME);
      default: return 4'd0;
    endcase
  endfunction

  seg7_decoder u_dec (
    .i_seg   (seg_display[6:0]),
    .o_digit (w_dec_digit),
    .o_valid (w_seg_ok)
  );

  // Classify the current sample and work out what the tracker expected
  always_comb begin
    w_phase     = light_to_phase(car_light);
    w_light_ok  = (w_phase != INVALID);
    w_ped_ok    = (pedestrian_light == (w_phase == RED));
    w_acquire   = w_light_ok && w_ped_ok && w_seg_ok &&
                  (w_dec_digit == phase_time(w_phase));
    w_exp_phase = (r_exp != 4'd0) ? r_phase : next_phase(r_phase);
    w_exp_digit = (r_exp != 4'd0) ? (r_exp - 4'd1) : phase_time(next_phase(r_phase));
    w_new_err   = '0;
    if (tick && (r_state == TRACK)) begin
      w_new_err[ERR_LIGHT] = !w_light_ok;
      w_new_err[ERR_PED]   = !w_ped_ok;
      w_new_err[ERR_SEG]   = !w_seg_ok;
      // Phase/count judgements only make sense for a legal light
      w_new_err[ERR_SEQ]   = w_light_ok && (w_phase != w_exp_phase);
      w_new_err[ERR_CNT]   = w_light_ok && (w_phase == w_exp_phase) &&
                             w_seg_ok && (w_dec_digit != w_exp_digit);
    end
    w_cycle_inc = tick && (r_state == TRACK) && (w_new_err == '0) &&
                  (r_phase == RED) && (r_exp == 4'd0);
    w_load_exp  = (r_state == ACQ) ? w_acquire : (w_new_err == '0);
  end

  // Monitor state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ACQ;
    else       r_state <= w_state_nxt;
  end

  // Next state: acquire on a legal phase-start sample, drop on any error or stall
  always_comb begin
    w_state_nxt = r_state;
    if (tick) begin
      if (r_state == ACQ) w_state_nxt = w_acquire ? TRACK : ACQ;
      else if (w_new_err != '0) w_state_nxt = ACQ;
    end else if (w_timeout) begin
      w_state_nxt = ACQ;
    end
  end

  // Output decode from registered state and sample registers
  always_comb begin
    w_locked    = (r_state == TRACK);
    locked      = w_locked;
    digit       = r_digit;
    digit_valid = r_digit_valid;
    phase       = r_phase;
    err_flags   = r_err;
    err_pulse   = r_pulse;
    cycle_count = r_cycle_cnt;
  end

  // Sample registers, sticky flags (new errors beat clear) and cycle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digit       <= 4'd0;
      r_digit_valid <= 1'b0;
      r_phase       <= INVALID;
      r_exp         <= 4'd0;
      r_err         <= '0;
      r_pulse       <= 1'b0;
      r_cycle_cnt   <= '0;
    end else begin
      r_pulse <= 1'b0;
      r_err   <= (clear_err ? {ERR_W{1'b0}} : r_err) | w_new_err;
      if (tick) begin
        r_phase       <= w_phase;
        r_digit_valid <= w_seg_ok;
        r_pulse       <= |w_new_err;
        if (w_seg_ok)   r_digit <= w_dec_digit;
        if (w_load_exp) r_exp   <= w_dec_digit;
        if (w_cycle_inc) r_cycle_cnt <= r_cycle_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

`ifdef MON_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  logic        r_stall;

  assign w_timeout = w_locked && !tick && (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign stall     = r_stall;

  // Cycles since the last tick, only counted while locked
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    r_to_cnt <= 32'd0;
    else if (tick || !w_locked || w_timeout) r_to_cnt <= 32'd0;
    else                          r_to_cnt <= r_to_cnt + 32'd1;
  end

  // Sticky stall flag; a new timeout wins over clear_err
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_stall <= 1'b0;
    else if (w_timeout) r_stall <= 1'b1;
    else if (clear_err) r_stall <= 1'b0;
  end

  assign w_unused = seg_display[7];
`else
  assign w_timeout = 1'b0;
  assign stall     = 1'b0;
  assign w_unused  = seg_display[7] ^ (TIMEOUT_CYCLES == 0);
`endif

endmodule
